// File: rtl/regbank_pkg.sv
// Shared types and helpers for the multi-port register bank.
package regbank_pkg;

   typedef enum logic {INIT, RUN} state_t;

   localparam int RF_DATA_W = 32;
   localparam int RF_ADDR_W = 5;
   localparam int RF_NUM_RD = 2;
   localparam int DEPTH     = 1 << RF_ADDR_W;

   // LSB offset of port p inside a packed per-port bus of field width w.
   function automatic int unsigned port_lsb(input int unsigned p, input int unsigned w);
      return p * w;
   endfunction

endpackage

// File: rtl/regbank_scoreboard.sv
// Pending-write scoreboard: one bit per register, set at issue, cleared at writeback.
module regbank_scoreboard
   import regbank_pkg::*;
#(
   parameter int ADDR_W = RF_ADDR_W,
   parameter int NUM_RD = RF_NUM_RD
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     set_en,
   input  logic [ADDR_W-1:0]        set_addr,
   input  logic                     clr_en,
   input  logic [ADDR_W-1:0]        clr_addr,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD-1:0]        pending
);

   localparam int N_REGS = 1 << ADDR_W;

   logic [N_REGS-1:0] r_pend;

   // Set is applied after clear so a same-address issue overrides the writeback.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pend <= '0;
      end else begin
         if (clr_en) r_pend[clr_addr] <= 1'b0;
         if (set_en) r_pend[set_addr] <= 1'b1;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_RD; gi++) begin : g_port
         logic [ADDR_W-1:0] w_addr;
         assign w_addr      = rd_addr[port_lsb(gi, ADDR_W) +: ADDR_W];
         assign pending[gi] = r_pend[w_addr];
      end
   endgenerate

endmodule

// File: rtl/regbank_mp.sv
// Multi-read-port register bank with hardware zero-init and pending-write scoreboard.
// Define RF_BYPASS_EN to forward same-cycle writeback data onto matching read ports.
module regbank_mp
   import regbank_pkg::*;
#(
   parameter int DATA_W = RF_DATA_W,
   parameter int ADDR_W = RF_ADDR_W,
   parameter int NUM_RD = RF_NUM_RD
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD*DATA_W-1:0] rd_data,
   output logic [NUM_RD-1:0]        rd_pending,
   input  logic                     wr_en,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic                     sb_set,
   input  logic [ADDR_W-1:0]        sb_addr,
   output logic                     init_busy
);

   localparam int N_REGS = 1 << ADDR_W;

   state_t            r_state;
   logic [ADDR_W-1:0] r_idx;
   logic [DATA_W-1:0] r_mem [N_REGS];

   logic              w_busy;
   logic              w_wr;
   logic              w_set;
   logic [NUM_RD-1:0] w_sb_pend;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= INIT;
         r_idx   <= '0;
      end else begin
         case (r_state)
            INIT: begin
               r_idx <= r_idx + 1'b1;
               if (r_idx == {ADDR_W{1'b1}}) r_state <= RUN;
            end
            default: r_state <= RUN;
         endcase
      end
   end

   assign w_busy    = rst | (r_state == INIT);
   assign init_busy = w_busy;
   assign w_wr      = ~w_busy & wr_en  & (wr_addr != '0);
   assign w_set     = ~w_busy & sb_set & (sb_addr != '0);

   // Storage has no reset so it maps to RAM; the init sequencer does the zeroing.
   always_ff @(posedge clk) begin
      if (!rst && r_state == INIT) begin
         r_mem[r_idx] <= '0;
      end else if (w_wr) begin
         r_mem[wr_addr] <= wr_data;
      end
   end

   regbank_scoreboard #(
      .ADDR_W (ADDR_W),
      .NUM_RD (NUM_RD)
   ) u_sb (
      .clk      (clk),
      .rst      (rst),
      .set_en   (w_set),
      .set_addr (sb_addr),
      .clr_en   (w_wr),
      .clr_addr (wr_addr),
      .rd_addr  (rd_addr),
      .pending  (w_sb_pend)
   );

   genvar gi;
   generate
      for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
         logic [ADDR_W-1:0] w_addr;
         logic [DATA_W-1:0] w_data;
         logic              w_pend;

         assign w_addr = rd_addr[port_lsb(gi, ADDR_W) +: ADDR_W];

         always_comb begin
            w_data = '0;
            w_pend = 1'b0;
            if (!w_busy && w_addr != '0) begin
               w_data = r_mem[w_addr];
               w_pend = w_sb_pend[gi];
`ifdef RF_BYPASS_EN
               if (w_wr && wr_addr == w_addr) begin
                  w_data = wr_data;
                  if (!(w_set && sb_addr == w_addr)) w_pend = 1'b0;
               end
`endif
            end
         end

         assign rd_data[port_lsb(gi, DATA_W) +: DATA_W] = w_data;
         assign rd_pending[gi]                           = w_pend;
      end
   endgenerate

endmodule

// File: tb/tb_regbank_mp.sv
// Self-checking bench for regbank_mp: directed scenarios plus randomized traffic vs. an array model.
module tb_regbank_mp;
   import regbank_pkg::*;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NR = 3;
   localparam int ND = DEPTH;

   logic             clk = 1'b0;
   logic             rst;
   logic [NR*AW-1:0] rd_addr;
   logic [NR*DW-1:0] rd_data;
   logic [NR-1:0]    rd_pending;
   logic             wr_en;
   logic [AW-1:0]    wr_addr;
   logic [DW-1:0]    wr_data;
   logic             sb_set;
   logic [AW-1:0]    sb_addr;
   logic             init_busy;

   int n_total = 0;
   int n_bad   = 0;
   int n_cyc   = 0;

   // Reference model: register contents, pending flags, remaining init cycles.
   logic [DW-1:0] m_mem [ND];
   bit            m_pend [ND];
   int            m_left = 0;

   always #5 clk = ~clk;

   regbank_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) dut (
      .clk        (clk),
      .rst        (rst),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .rd_pending (rd_pending),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .sb_set     (sb_set),
      .sb_addr    (sb_addr),
      .init_busy  (init_busy)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] rdp(input int p);
      return rd_data[p*DW +: DW];
   endfunction

   task automatic set_rd(input int p, input int a);
      rd_addr[p*AW +: AW] = AW'(a);
   endtask

   task automatic idle();
      wr_en  = 1'b0;
      sb_set = 1'b0;
   endtask

   task automatic drive_wr(input int a, input logic [DW-1:0] d);
      wr_en   = 1'b1;
      wr_addr = AW'(a);
      wr_data = d;
   endtask

   // Check every output against the model, then clock once and advance the model.
   task automatic cycle();
      bit            exp_busy;
      logic [AW-1:0] a;
      logic [DW-1:0] ed;
      bit            ep;
      #1;
      exp_busy = rst || (m_left > 0);
      check("busy", {63'd0, init_busy}, {63'd0, exp_busy});
      for (int p = 0; p < NR; p++) begin
         a  = rd_addr[p*AW +: AW];
         ed = '0;
         ep = 1'b0;
         if (!exp_busy && a != 0) begin
            ed = m_mem[a];
            ep = m_pend[a];
`ifdef RF_BYPASS_EN
            if (wr_en && wr_addr == a) begin
               ed = wr_data;
               if (!(sb_set && sb_addr == a)) ep = 1'b0;
            end
`endif
         end
         check($sformatf("rd_data%0d", p), {32'd0, rdp(p)}, {32'd0, ed});
         check($sformatf("rd_pend%0d", p), {63'd0, rd_pending[p]}, {63'd0, ep});
      end
      $display("txn %0d rst=%0b busy=%0b wr=%0b@%0d=%h sb=%0b@%0d rd=%h", n_cyc, rst, init_busy,
               wr_en, wr_addr, wr_data, sb_set, sb_addr, rd_addr);
      n_cyc++;
      @(posedge clk);
      if (rst) begin
         m_left = ND;
         for (int i = 0; i < ND; i++) begin
            m_mem[i]  = '0;
            m_pend[i] = 1'b0;
         end
      end else if (m_left > 0) begin
         m_left--;
      end else begin
         if (wr_en && wr_addr != 0) begin
            m_mem[wr_addr]  = wr_data;
            m_pend[wr_addr] = 1'b0;
         end
         if (sb_set && sb_addr != 0) m_pend[sb_addr] = 1'b1;
      end
      #1;
   endtask

   // Clock until init_busy drops (bounded); returns the number of busy cycles seen.
   task automatic count_busy(output int cnt);
      cnt = 0;
      for (int i = 0; i < 3 * ND; i++) begin
         #1;
         if (!init_busy) break;
         cnt++;
         cycle();
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int            cnt;
      logic [DW-1:0] r31;
      rst     = 1'b1;
      rd_addr = '0;
      wr_addr = '0;
      wr_data = '0;
      sb_addr = '0;
      idle();
      @(posedge clk);
      #1;

      // Reset and init sequence length, then everything reads zero.
      cycle();
      cycle();
      rst = 1'b0;
      count_busy(cnt);
      check("init_len", 64'(cnt), 64'(ND));
      for (int a = 0; a < ND; a++) begin
         set_rd(a % NR, a);
         #1;
         check("init_zero", {32'd0, rdp(a % NR)}, 64'd0);
         cycle();
      end

      // Write then read back; writes to r0 are dropped.
      drive_wr(5, 32'hDEAD_BEEF);
      cycle();
      idle();
      set_rd(0, 5);
      #1;
      check("r5_read", {32'd0, rdp(0)}, 64'hDEAD_BEEF);
      drive_wr(0, 32'h1234);
      cycle();
      idle();
      set_rd(0, 0);
      #1;
      check("r0_read", {32'd0, rdp(0)}, 64'd0);
      cycle();

      // Scoreboard set, clear by writeback, and set-beats-clear on collision.
      sb_set  = 1'b1;
      sb_addr = 7;
      cycle();
      idle();
      set_rd(0, 7);
      #1;
      check("r7_pend_set", {63'd0, rd_pending[0]}, 64'd1);
      drive_wr(7, 32'h55);
      cycle();
      idle();
      #1;
      check("r7_pend_clr", {63'd0, rd_pending[0]}, 64'd0);
      drive_wr(7, 32'h55);
      sb_set  = 1'b1;
      sb_addr = 7;
      cycle();
      idle();
      #1;
      check("r7_pend_win", {63'd0, rd_pending[0]}, 64'd1);
      check("r7_data", {32'd0, rdp(0)}, 64'h55);
      cycle();

      // Same-cycle write/read on r3.
      drive_wr(3, 32'h1111_2222);
      cycle();
      drive_wr(3, 32'hA5A5_A5A5);
      set_rd(1, 3);
      #1;
`ifdef RF_BYPASS_EN
      check("r3_same_cyc", {32'd0, rdp(1)}, 64'hA5A5_A5A5);
`else
      check("r3_same_cyc", {32'd0, rdp(1)}, 64'h1111_2222);
`endif
      cycle();
      idle();
      #1;
      check("r3_next_cyc", {32'd0, rdp(1)}, 64'hA5A5_A5A5);
      cycle();

      // Three ports on r9, then on r0/r9/r31.
      drive_wr(9, 32'h0F0F);
      cycle();
      r31 = $urandom;
      drive_wr(31, r31);
      cycle();
      idle();
      for (int p = 0; p < NR; p++) set_rd(p, 9);
      #1;
      for (int p = 0; p < NR; p++) check($sformatf("r9_port%0d", p), {32'd0, rdp(p)}, 64'h0F0F);
      cycle();
      set_rd(0, 0);
      set_rd(1, 9);
      set_rd(2, 31);
      #1;
      check("mix_r0", {32'd0, rdp(0)}, 64'd0);
      check("mix_r9", {32'd0, rdp(1)}, 64'h0F0F);
      check("mix_r31", {32'd0, rdp(2)}, {32'd0, r31});
      cycle();

      // Reset at init index 10; writes attempted during init must not land.
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      for (int i = 0; i < 10; i++) cycle();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      drive_wr(3, 32'hFFFF_FFFF);
      sb_set  = 1'b1;
      sb_addr = 3;
      count_busy(cnt);
      check("reinit_len", 64'(cnt), 64'(ND));
      idle();
      set_rd(0, 3);
      #1;
      check("init_wr_ign", {32'd0, rdp(0)}, 64'd0);
      check("init_sb_ign", {63'd0, rd_pending[0]}, 64'd0);
      cycle();

      // Randomized traffic, biased toward a few registers to provoke collisions.
      for (int n = 0; n < 800; n++) begin
         rst     = ($urandom_range(0, 249) == 0);
         wr_en   = $urandom_range(0, 1);
         wr_addr = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 5));
         wr_data = $urandom;
         sb_set  = ($urandom_range(0, 2) == 0);
         sb_addr = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 5));
         for (int p = 0; p < NR; p++)
            set_rd(p, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, ND - 1))
                                                  : int'($urandom_range(0, 5)));
         cycle();
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
